// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns "<R|G|B><0-999><CR|LF>" byte streams into R/G/B duty values and answers ACK/NAK.
// Optional macro CMD_TIMEOUT_EN abandons a partial command after TIMEOUT_CYCLES idle clocks.
module uart_cmd_parser #(
   parameter logic [7:0]  ACK_BYTE       = 8'h4B,
   parameter logic [7:0]  NAK_BYTE       = 8'h3F,
   parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_done,
   input  logic       tx_done,
   input  logic       err_clear,
   output logic [7:0] tx_byte,
   output logic       tx_send,
   output logic [7:0] duty_r,
   output logic [7:0] duty_g,
   output logic [7:0] duty_b,
   output logic       cmd_strobe,
   output logic       err_overrun
);

   typedef enum logic [1:0] {IDLE, CHAN, NUM, SKIP} state_t;
   typedef enum logic [2:0] {CLS_CHAN, CLS_DIGIT, CLS_TERM, CLS_SPACE, CLS_OTHER} cls_t;
   typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_t;

   state_t     state, state_n;
   cls_t       cls;
   chan_t      chan, chan_sel;
   logic [2:0] rx_sync, tx_sync;
   logic       rx_edge, tx_edge;
   logic [7:0] byte_q;
   logic       byte_vld;
   logic [9:0] acc;
   logic [1:0] cnt;
   logic [7:0] sat_val;
   logic       ld_chan, ld_first, ld_digit, commit, resp_req, resp_ack;

   // Two flops synchronise, the third remembers the previous level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync  <= '0;
         tx_sync  <= '0;
         byte_q   <= '0;
         byte_vld <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere in clocked logic so each flop samples pre-edge values.
         rx_sync  <= {rx_sync[1:0], rx_done};
         tx_sync  <= {tx_sync[1:0], tx_done};
         byte_vld <= rx_edge;
         if (rx_edge) byte_q <= rx_byte;
      end
   end

   assign rx_edge = rx_sync[1] & ~rx_sync[2];
   assign tx_edge = tx_sync[1] & ~tx_sync[2];

   always_comb begin
      logic [7:0] lower;
      lower    = byte_q | 8'h20;
      cls      = CLS_OTHER;
      chan_sel = CH_R;
      case (lower)
         8'h72:   cls = CLS_CHAN;
         8'h67: begin cls = CLS_CHAN; chan_sel = CH_G; end
         8'h62: begin cls = CLS_CHAN; chan_sel = CH_B; end
         default: ;
      endcase
      if (byte_q >= 8'h30 && byte_q <= 8'h39) cls = CLS_DIGIT;
      else if (byte_q == 8'h0D || byte_q == 8'h0A) cls = CLS_TERM;
      else if (byte_q == 8'h20) cls = CLS_SPACE;
   end

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] TO_VAL = IW'(TIMEOUT_CYCLES);
   logic [IW-1:0] idle_cnt;
   logic          timed_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         idle_cnt <= '0;
      else if (byte_vld || state == IDLE) idle_cnt <= '0;
      else if (idle_cnt != TO_VAL)        idle_cnt <= idle_cnt + 1'b1;
   end

   assign timed_out = (state != IDLE) && (idle_cnt == TO_VAL);
`else
   logic timed_out;
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_n  = state;
      ld_chan  = 1'b0;
      ld_first = 1'b0;
      ld_digit = 1'b0;
      commit   = 1'b0;
      resp_req = 1'b0;
      resp_ack = 1'b0;
      if (byte_vld) begin
         unique case (state)
            IDLE: case (cls)
               CLS_CHAN:            begin ld_chan = 1'b1; state_n = CHAN; end
               CLS_SPACE, CLS_TERM: ;
               default:             state_n = SKIP;
            endcase
            CHAN: case (cls)
               CLS_DIGIT: begin ld_first = 1'b1; state_n = NUM; end
               CLS_SPACE: ;
               CLS_TERM:  begin resp_req = 1'b1; state_n = IDLE; end
               default:   state_n = SKIP;
            endcase
            NUM: case (cls)
               CLS_DIGIT: if (cnt < 2'd3) ld_digit = 1'b1;
                          else            state_n  = SKIP;
               CLS_TERM: begin
                  commit   = 1'b1;
                  resp_req = 1'b1;
                  resp_ack = 1'b1;
                  state_n  = IDLE;
               end
               default:   state_n = SKIP;
            endcase
            SKIP: if (cls == CLS_TERM) begin resp_req = 1'b1; state_n = IDLE; end
            default: state_n = IDLE;
         endcase
      end else if (timed_out) begin
         state_n = IDLE;
      end
   end

   assign sat_val = (acc > 10'd255) ? 8'hFF : acc[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan       <= CH_R;
         acc        <= '0;
         cnt        <= '0;
         duty_r     <= '0;
         duty_g     <= '0;
         duty_b     <= '0;
         cmd_strobe <= 1'b0;
      end else begin
         cmd_strobe <= commit;
         if (ld_chan) begin
            chan <= chan_sel;
            acc  <= '0;
            cnt  <= '0;
         end else if (ld_first) begin
            acc <= {6'd0, byte_q[3:0]};
            cnt <= 2'd1;
         end else if (ld_digit) begin
            acc <= acc * 10'd10 + {6'd0, byte_q[3:0]};
            cnt <= cnt + 2'd1;
         end
         if (commit) begin
            case (chan)
               CH_R:    duty_r <= sat_val;
               CH_G:    duty_g <= sat_val;
               CH_B:    duty_b <= sat_val;
               default: ;
            endcase
         end
      end
   end

   // A response raised while one is still in flight is dropped and flagged; set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_byte     <= '0;
         tx_send     <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (resp_req && !tx_send) begin
            tx_byte <= resp_ack ? ACK_BYTE : NAK_BYTE;
            tx_send <= 1'b1;
         end else if (tx_edge) begin
            tx_send <= 1'b0;
         end
         if (resp_req && tx_send) err_overrun <= 1'b1;
         else if (err_clear)      err_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus random command lines
// checked against a line-oriented reference model.
module tb_uart_cmd_parser;

   localparam int TB_TIMEOUT = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_byte = '0;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic       err_clear = 1'b0;
   logic [7:0] tx_byte, duty_r, duty_g, duty_b;
   logic       tx_send, cmd_strobe, err_overrun;

   uart_cmd_parser #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done), .tx_done(tx_done),
      .err_clear(err_clear), .tx_byte(tx_byte), .tx_send(tx_send), .duty_r(duty_r),
      .duty_g(duty_g), .duty_b(duty_b), .cmd_strobe(cmd_strobe), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit auto_ack = 1'b1;

   // Observed traffic
   logic [7:0] got_resp[$];
   int         strobe_cnt = 0;
   int         stab_err = 0;
   logic       prev_send = 1'b0;
   logic [7:0] prev_byte = '0;

   // Reference model state
   logic [7:0] line[$];
   logic [7:0] exp_resp[$];
   logic [7:0] exp_duty[3] = '{8'h00, 8'h00, 8'h00};
   int         exp_strobes = 0;

   always @(negedge clk) begin
      if (tx_send === 1'b1 && prev_send !== 1'b1) got_resp.push_back(tx_byte);
      if (tx_send === 1'b1 && prev_send === 1'b1 && tx_byte !== prev_byte) stab_err++;
      if (cmd_strobe === 1'b1) strobe_cnt++;
      prev_send <= tx_send;
      prev_byte <= tx_byte;
   end

   // Behaves like uart_tx: answers a send request with a tx_done level after a short delay.
   always begin
      @(negedge clk);
      if (auto_ack && tx_send === 1'b1) begin
         repeat (3) @(negedge clk);
         tx_done = 1'b1;
         for (int i = 0; i < 20 && tx_send === 1'b1; i++) @(negedge clk);
         tx_done = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // A whole line is judged at its terminator: optional spaces, a channel letter,
   // optional spaces, 1-3 digits, nothing else.
   task automatic eval_line();
      int i = 0;
      int nd = 0;
      int val = 0;
      int ch;
      while (i < line.size() && line[i] == 8'h20) i++;
      if (i == line.size()) return;
      case (line[i] | 8'h20)
         8'h72:   ch = 0;
         8'h67:   ch = 1;
         8'h62:   ch = 2;
         default: ch = -1;
      endcase
      if (ch < 0) begin
         exp_resp.push_back(8'h3F);
         return;
      end
      i++;
      while (i < line.size() && line[i] == 8'h20) i++;
      while (i < line.size() && line[i] >= 8'h30 && line[i] <= 8'h39) begin
         val = val * 10 + int'(line[i] - 8'h30);
         nd++;
         i++;
      end
      if (nd == 0 || nd > 3 || i != line.size()) begin
         exp_resp.push_back(8'h3F);
      end else begin
         exp_duty[ch] = (val > 255) ? 8'hFF : 8'(val);
         exp_resp.push_back(8'h4B);
         exp_strobes++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b;
      rx_done = 1'b1;
      repeat ($urandom_range(2, 6)) @(negedge clk);
      rx_done = 1'b0;
      repeat ($urandom_range(3, 5)) @(negedge clk);
      if (b == 8'h0D || b == 8'h0A) begin
         eval_line();
         line.delete();
      end else begin
         line.push_back(b);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      repeat (10) @(negedge clk);
      while (tx_send === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (tx_send !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: tx_send=%b after 200 cycles, required 0", name, tx_send);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (tx_send !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_tx_send: got %b, required 0", tx_send);
      end
      rst_n = 1'b1;
      line.delete();
      exp_duty = '{8'h00, 8'h00, 8'h00};
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({duty_r, duty_g, duty_b, tx_byte} !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_regs: got %h, required 00000000", {duty_r, duty_g, duty_b, tx_byte});
      end
      vectors++;
      if ({tx_send, cmd_strobe, err_overrun} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, required 000", {tx_send, cmd_strobe, err_overrun});
      end
   endtask

   task automatic test_ack_basic();
      int gb = got_resp.size();
      int sb = strobe_cnt;
      send_str("R128\r");
      wait_quiet("basic_tx_release");
      vectors++;
      if (duty_r !== 8'h80) begin
         miscompares++;
         $display("FAIL basic_duty_r: got %h, required 80", duty_r);
      end
      vectors++;
      if (strobe_cnt - sb !== 1) begin
         miscompares++;
         $display("FAIL basic_strobe: got %0d pulses, required 1", strobe_cnt - sb);
      end
      vectors++;
      if (got_resp.size() - gb !== 1 || got_resp[gb] !== 8'h4B) begin
         miscompares++;
         $display("FAIL basic_ack: got %0d responses (first %h), required 1 x 4b",
                  got_resp.size() - gb, got_resp.size() > gb ? got_resp[gb] : 8'hxx);
      end
   endtask

   task automatic test_saturate();
      int gb = got_resp.size();
      int sb = strobe_cnt;
      send_str("g300\n");
      wait_quiet("sat_tx_release");
      vectors++;
      if (duty_g !== 8'hFF || got_resp.size() - gb !== 1 || got_resp[gb] !== 8'h4B) begin
         miscompares++;
         $display("FAIL sat_g300: duty_g=%h responses=%0d, required ff with 1 x 4b",
                  duty_g, got_resp.size() - gb);
      end
      gb = got_resp.size();
      send_str("b7\r\n");
      wait_quiet("crlf_tx_release");
      vectors++;
      if (duty_b !== 8'h07 || got_resp.size() - gb !== 1 || got_resp[gb] !== 8'h4B) begin
         miscompares++;
         $display("FAIL crlf_b7: duty_b=%h responses=%0d, required 07 with 1 x 4b",
                  duty_b, got_resp.size() - gb);
      end
      vectors++;
      if (strobe_cnt - sb !== 2) begin
         miscompares++;
         $display("FAIL sat_strobes: got %0d, required 2", strobe_cnt - sb);
      end
   endtask

   task automatic test_nak();
      string cmds[3] = '{"X5\r", "R\r", "B1234\r"};
      int sb = strobe_cnt;
      for (int k = 0; k < 3; k++) begin
         int gb = got_resp.size();
         send_str(cmds[k]);
         wait_quiet("nak_tx_release");
         vectors++;
         if (got_resp.size() - gb !== 1 || got_resp[gb] !== 8'h3F) begin
            miscompares++;
            $display("FAIL nak_%0d: got %0d responses, required 1 x 3f", k, got_resp.size() - gb);
         end
      end
      vectors++;
      if ({duty_r, duty_g, duty_b} !== 24'h80FF07 || strobe_cnt != sb) begin
         miscompares++;
         $display("FAIL nak_duties: got %h strobes %0d, required 80ff07 strobes 0",
                  {duty_r, duty_g, duty_b}, strobe_cnt - sb);
      end
   endtask

   task automatic test_overrun();
      int gb = got_resp.size();
      int sb = strobe_cnt;
      auto_ack = 1'b0;
      send_str("R10\r");
      send_str("G20\r");
      repeat (10) @(negedge clk);
      vectors++;
      if (duty_r !== 8'd10 || duty_g !== 8'd20 || strobe_cnt - sb !== 2) begin
         miscompares++;
         $display("FAIL ovr_duties: got r=%0d g=%0d strobes=%0d, required 10 20 2",
                  duty_r, duty_g, strobe_cnt - sb);
      end
      vectors++;
      if (got_resp.size() - gb !== 1 || got_resp[gb] !== 8'h4B || tx_send !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_pending: got %0d responses tx_send=%b, required 1 x 4b pending",
                  got_resp.size() - gb, tx_send);
      end
      vectors++;
      if (err_overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_flag: got %b, required 1", err_overrun);
      end
      @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      vectors++;
      if (err_overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_clear: got %b, required 0", err_overrun);
      end
      auto_ack = 1'b1;
      wait_quiet("ovr_tx_release");
   endtask

   task automatic test_reset_mid();
      int gb;
      int sb;
      send_str("B25");
      do_reset();
      gb = got_resp.size();
      sb = strobe_cnt;
      send_str("\r");
      wait_quiet("mid_tx_release");
      vectors++;
      if (got_resp.size() != gb || strobe_cnt != sb || {duty_r, duty_g, duty_b} !== 24'h0) begin
         miscompares++;
         $display("FAIL mid_reset: got %0d responses duties %h, required 0 and 000000",
                  got_resp.size() - gb, {duty_r, duty_g, duty_b});
      end
   endtask

   task automatic test_timeout();
      int gb = got_resp.size();
      send_str("R50");
      repeat (TB_TIMEOUT + 10) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
      line.delete();
`endif
      send_str("\r");
      wait_quiet("to_tx_release");
`ifdef CMD_TIMEOUT_EN
      vectors++;
      if (got_resp.size() != gb || duty_r !== 8'd0) begin
         miscompares++;
         $display("FAIL timeout_drop: got %0d responses duty_r=%0d, required 0 and 0",
                  got_resp.size() - gb, duty_r);
      end
`else
      vectors++;
      if (got_resp.size() - gb !== 1 || got_resp[gb] !== 8'h4B || duty_r !== 8'd50) begin
         miscompares++;
         $display("FAIL timeout_persist: got %0d responses duty_r=%0d, required 1 x 4b and 50",
                  got_resp.size() - gb, duty_r);
      end
`endif
   endtask

   task automatic test_random();
      logic [7:0] chans[6] = '{8'h52, 8'h47, 8'h42, 8'h72, 8'h67, 8'h62};
      logic [7:0] junk[8]  = '{8'h52, 8'h67, 8'h35, 8'h30, 8'h20, 8'h58, 8'h40, 8'h01};
      for (int n = 0; n < 40; n++) begin
         logic [7:0] bytes[$];
         int kind = $urandom_range(0, 9);
         int t = $urandom_range(0, 2);
         int gb = got_resp.size();
         int eb = exp_resp.size();
         int sb = strobe_cnt;
         int xb = exp_strobes;
         if (kind < 7) begin
            int nd = (kind == 6) ? 4 : $urandom_range(1, 3);
            repeat ($urandom_range(0, 2)) bytes.push_back(8'h20);
            bytes.push_back(chans[$urandom_range(0, 5)]);
            repeat ($urandom_range(0, 1)) bytes.push_back(8'h20);
            repeat (nd) bytes.push_back(8'(8'h30 + $urandom_range(0, 9)));
         end else begin
            repeat ($urandom_range(1, 5)) bytes.push_back(junk[$urandom_range(0, 7)]);
         end
         if (t != 1) bytes.push_back(8'h0D);
         if (t != 0) bytes.push_back(8'h0A);
         foreach (bytes[k]) send_byte(bytes[k]);
         wait_quiet("rnd_tx_release");
         vectors++;
         if (got_resp.size() - gb != exp_resp.size() - eb ||
             (exp_resp.size() > eb && got_resp[gb] !== exp_resp[eb])) begin
            miscompares++;
            $display("FAIL rnd_resp line %0d: got %0d responses, required %0d (first %h)",
                     n, got_resp.size() - gb, exp_resp.size() - eb,
                     exp_resp.size() > eb ? exp_resp[eb] : 8'h00);
         end
         vectors++;
         if ({duty_r, duty_g, duty_b} !== {exp_duty[0], exp_duty[1], exp_duty[2]} ||
             strobe_cnt - sb != exp_strobes - xb) begin
            miscompares++;
            $display("FAIL rnd_duty line %0d: got %h strobes %0d, required %h strobes %0d", n,
                     {duty_r, duty_g, duty_b}, strobe_cnt - sb,
                     {exp_duty[0], exp_duty[1], exp_duty[2]}, exp_strobes - xb);
         end
      end
      vectors++;
      if (err_overrun !== 1'b0 || stab_err != 0) begin
         miscompares++;
         $display("FAIL rnd_integrity: err_overrun=%b tx_byte changes=%0d, required 0 and 0",
                  err_overrun, stab_err);
      end
   endtask

   initial begin
      test_reset();
      test_ack_basic();
      test_saturate();
      test_nak();
      test_overrun();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
